// File: rtl/sw_led_pio.sv
// sw_led_pio: Avalon-MM switch/LED peripheral.
// Switch inputs are synchronised and debounced per bit. Debounced edges are
// captured into a sticky W1C register that drives a maskable level interrupt.
// The LED register can be written whole or updated with atomic set/clear.
//
// Ports:
//   clk_clk          system clock
//   reset_reset      synchronous active-high reset
//   avs_*            Avalon-MM slave (3-bit word address, 1-cycle read latency)
//   irq              level interrupt, |(EDGE & MASK)
//   switches_export  raw asynchronous switch pins
//   ledr_export      registered LED drive
module sw_led_pio #(
  parameter int unsigned          SW_WIDTH        = 10,
  parameter int unsigned          LED_WIDTH       = 10,
  parameter int unsigned          SYNC_STAGES     = 2,
  parameter int unsigned          DEBOUNCE_CYCLES = 50000,
  parameter int unsigned          EDGE_TYPE       = 2,
  parameter logic [LED_WIDTH-1:0] LED_RESET       = '0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic [2:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  output logic                 irq,
  input  logic [SW_WIDTH-1:0]  switches_export,
  output logic [LED_WIDTH-1:0] ledr_export
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ADDR_DATA    = 3'd0,
    ADDR_LED     = 3'd1,
    ADDR_MASK    = 3'd2,
    ADDR_EDGE    = 3'd3,
    ADDR_LED_SET = 3'd4,
    ADDR_LED_CLR = 3'd5,
    ADDR_ID      = 3'd6,
    ADDR_RSVD    = 3'd7
  } reg_addr_e;

  reg_addr_e addr;
  assign addr = reg_addr_e'(avs_address);

  // Synchroniser chain
  logic [SW_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [SW_WIDTH-1:0] sync;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= switches_export;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Per-bit debouncer
  logic [CNT_W-1:0]    cnt_q [SW_WIDTH];
  logic [CNT_W-1:0]    cnt_d [SW_WIDTH];
  logic [SW_WIDTH-1:0] stable_q, stable_d;

  always_comb begin
    stable_d = stable_q;
    for (int unsigned i = 0; i < SW_WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Edge qualification uses the next stable value so EDGE/irq rise on the
  // same clock edge as stable.
  logic [SW_WIDTH-1:0] rise, fall, edge_evt;

  always_comb begin
    rise = stable_d & ~stable_q;
    fall = ~stable_d & stable_q;
    case (EDGE_TYPE)
      0:       edge_evt = rise;
      1:       edge_evt = fall;
      default: edge_evt = rise | fall;
    endcase
  end

  // Register file
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [SW_WIDTH-1:0]  mask_q, mask_d;
  logic [SW_WIDTH-1:0]  edge_q, edge_d;
  logic [SW_WIDTH-1:0]  w1c;
  logic [31:0]          rdata_q, rdata_d;
  logic [LED_WIDTH-1:0] wd_led;
  logic [SW_WIDTH-1:0]  wd_sw;
  logic                 unused_wdata;

  assign wd_led       = avs_writedata[LED_WIDTH-1:0];
  assign wd_sw        = avs_writedata[SW_WIDTH-1:0];
  assign unused_wdata = ^avs_writedata;

  always_comb begin
    led_d  = led_q;
    mask_d = mask_q;
    w1c    = '0;
    if (avs_write) begin
      case (addr)
        ADDR_LED:     led_d  = wd_led;
        ADDR_MASK:    mask_d = wd_sw;
        ADDR_EDGE:    w1c    = wd_sw;
        ADDR_LED_SET: led_d  = led_q | wd_led;
        ADDR_LED_CLR: led_d  = led_q & ~wd_led;
        default:      ;
      endcase
    end
    // Set has priority over a simultaneous clear
    edge_d = (edge_q & ~w1c) | edge_evt;
  end

  always_comb begin
    rdata_d = '0;
    if (avs_read) begin
      case (addr)
        ADDR_DATA: rdata_d = 32'(stable_q);
        ADDR_LED:  rdata_d = 32'(led_q);
        ADDR_MASK: rdata_d = 32'(mask_q);
        ADDR_EDGE: rdata_d = 32'(edge_q);
        ADDR_ID:   rdata_d = {8'hA5, 8'(LED_WIDTH), 8'(SW_WIDTH), 8'(EDGE_TYPE)};
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      stable_q <= '0;
      cnt_q    <= '{default: '0};
      led_q    <= LED_RESET;
      mask_q   <= '0;
      edge_q   <= '0;
      rdata_q  <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
      mask_q   <= mask_d;
      edge_q   <= edge_d;
      rdata_q  <= rdata_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign ledr_export  = led_q;
  assign irq          = |(edge_q & mask_q);

endmodule

// File: tb/tb_sw_led_pio.sv
// Self-checking bench for sw_led_pio: two instances (both-edge and
// rising-only capture) share one bus and switch bank.
module tb_sw_led_pio;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam logic [31:0] ID_A = 32'hA50A0A02;
  localparam logic [31:0] ID_B = 32'hA50A0A00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] wdata = '0;
  logic [9:0]  sw = '0;
  logic [31:0] rdA, rdB;
  logic        irqA, irqB;
  logic [9:0]  ledA, ledB;

  always #5 clk = ~clk;

  sw_led_pio #(.SW_WIDTH(10), .LED_WIDTH(10), .SYNC_STAGES(SYNC),
               .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(2), .LED_RESET(10'h155)) dut_a (
    .clk_clk(clk), .reset_reset(rst), .avs_address(addr), .avs_read(rd),
    .avs_write(wr), .avs_writedata(wdata), .avs_readdata(rdA), .irq(irqA),
    .switches_export(sw), .ledr_export(ledA));

  sw_led_pio #(.SW_WIDTH(10), .LED_WIDTH(10), .SYNC_STAGES(SYNC),
               .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(0), .LED_RESET(10'h155)) dut_b (
    .clk_clk(clk), .reset_reset(rst), .avs_address(addr), .avs_read(rd),
    .avs_write(wr), .avs_writedata(wdata), .avs_readdata(rdB), .irq(irqB),
    .switches_export(sw), .ledr_export(ledB));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference model
  bit          m_valid = 0;
  logic [9:0]  m_stable, m_edgeA, m_edgeB, m_mask, m_led;
  logic [31:0] m_rdA, m_rdB;
  logic [9:0]  pin_hist[$];
  logic [9:0]  seen_hist[$];

  function automatic logic [31:0] rd_model(input logic [2:0] a, input logic [9:0] ev,
                                           input logic [31:0] id);
    case (a)
      3'd0:    return {22'd0, m_stable};
      3'd1:    return {22'd0, m_led};
      3'd2:    return {22'd0, m_mask};
      3'd3:    return {22'd0, ev};
      3'd6:    return id;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic [9:0] seen, nst, chg, w1c;
    bit all_diff;
    if (rst) begin
      m_valid = 1; m_stable = '0; m_edgeA = '0; m_edgeB = '0; m_mask = '0;
      m_led = 10'h155; m_rdA = '0; m_rdB = '0;
      pin_hist.delete(); seen_hist.delete();
      return;
    end
    m_rdA = rd ? rd_model(addr, m_edgeA, ID_A) : 32'd0;
    m_rdB = rd ? rd_model(addr, m_edgeB, ID_B) : 32'd0;
    // Debouncer sees the pin level sampled SYNC edges earlier
    pin_hist.push_back(sw);
    seen = (pin_hist.size() > SYNC) ? pin_hist[pin_hist.size()-1-SYNC] : 10'd0;
    if (pin_hist.size() > SYNC + 1) void'(pin_hist.pop_front());
    seen_hist.push_back(seen);
    if (seen_hist.size() > DB) void'(seen_hist.pop_front());
    // Accept a new level once the last DB observed samples all disagree
    nst = m_stable;
    for (int b = 0; b < 10; b++) begin
      all_diff = (seen_hist.size() == DB);
      foreach (seen_hist[k]) if (seen_hist[k][b] == m_stable[b]) all_diff = 0;
      if (all_diff) nst[b] = ~m_stable[b];
    end
    chg = nst ^ m_stable;
    w1c = (wr && addr == 3'd3) ? wdata[9:0] : 10'd0;
    m_edgeA = (m_edgeA & ~w1c) | chg;
    m_edgeB = (m_edgeB & ~w1c) | (chg & nst);
    if (wr) begin
      case (addr)
        3'd1: m_led = wdata[9:0];
        3'd2: m_mask = wdata[9:0];
        3'd4: m_led = m_led | wdata[9:0];
        3'd5: m_led = m_led & ~wdata[9:0];
        default: ;
      endcase
    end
    m_stable = nst;
  endtask

  // One bus cycle: drive, clock, update model, compare 1ns after the edge
  task automatic cycle(input bit r, input bit w, input logic [2:0] a, input logic [31:0] d);
    rd = r; wr = w; addr = a; wdata = d;
    @(posedge clk);
    model_step();
    #1;
    if (m_valid) begin
      check("ledrA", 32'(ledA), 32'(m_led));
      check("ledrB", 32'(ledB), 32'(m_led));
      check("irqA", 32'(irqA), 32'(|(m_edgeA & m_mask)));
      check("irqB", 32'(irqB), 32'(|(m_edgeB & m_mask)));
      if (r) begin
        check("rdA", rdA, m_rdA);
        check("rdB", rdB, m_rdB);
      end
    end
    rd = 0; wr = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 3'd0, 32'd0);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] va, output logic [31:0] vb);
    cycle(1, 0, a, 32'd0);
    va = rdA; vb = rdB;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    cycle(0, 1, a, d);
  endtask

  typedef struct {
    bit          is_wr;
    logic [2:0]  a;
    logic [31:0] d;
    logic [31:0] exp;   // ledr after a write, readdata for a read
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] va, vb;

    vecs.push_back('{1, 3'd1, 32'h0000_00F0, 32'h0F0});
    vecs.push_back('{1, 3'd4, 32'h0000_0003, 32'h0F3});
    vecs.push_back('{1, 3'd5, 32'h0000_0010, 32'h0E3});
    vecs.push_back('{0, 3'd1, 32'h0,         32'h0E3});
    vecs.push_back('{0, 3'd4, 32'h0,         32'h000});
    vecs.push_back('{0, 3'd5, 32'h0,         32'h000});
    vecs.push_back('{1, 3'd7, 32'hFFFF_FFFF, 32'h0E3});
    vecs.push_back('{0, 3'd7, 32'h0,         32'h000});
    vecs.push_back('{1, 3'd0, 32'h0000_03FF, 32'h0E3});
    vecs.push_back('{0, 3'd0, 32'h0,         32'h000});
    vecs.push_back('{1, 3'd6, 32'h0,         32'h0E3});
    vecs.push_back('{0, 3'd6, 32'h0,         ID_A});
    vecs.push_back('{1, 3'd2, 32'hFFFF_FFFF, 32'h0E3});
    vecs.push_back('{0, 3'd2, 32'h0,         32'h3FF});
    vecs.push_back('{1, 3'd1, 32'hFFFF_FFFF, 32'h3FF});
    vecs.push_back('{0, 3'd1, 32'h0,         32'h3FF});
    vecs.push_back('{1, 3'd2, 32'h0,         32'h3FF});

    // Reset state
    rst = 1; idle(3); rst = 0;
    check("reset_ledr", 32'(ledA), 32'h155);
    check("reset_irq", 32'(irqA), 32'd0);
    bus_read(3'd0, va, vb); check("reset_DATA", va, 32'd0);
    bus_read(3'd2, va, vb); check("reset_MASK", va, 32'd0);
    bus_read(3'd3, va, vb); check("reset_EDGE", va, 32'd0);
    bus_read(3'd6, va, vb); check("ID_A", va, ID_A); check("ID_B", vb, ID_B);

    // Short glitch rejected
    bus_write(3'd2, 32'h001);
    sw = 10'h001; idle(3); sw = 10'h000; idle(8);
    bus_read(3'd0, va, vb); check("glitch_DATA", va, 32'd0);
    bus_read(3'd3, va, vb); check("glitch_EDGE", va, 32'd0);

    // Accepted exactly SYNC+DB edges after the pin change
    sw = 10'h001;
    for (int i = 1; i <= 8; i++) begin
      idle(1);
      check($sformatf("accept_irq_%0d", i), 32'(irqA), 32'(i >= SYNC + DB));
    end
    bus_read(3'd0, va, vb); check("accept_DATA", va, 32'h001);
    bus_read(3'd3, va, vb); check("accept_EDGE", va, 32'h001);

    // W1C clears irq on the next edge
    bus_write(3'd3, 32'h001);
    check("w1c_irq", 32'(irqA), 32'd0);

    // W1C in the same cycle as a falling edge event: set wins on A
    sw = 10'h000; idle(SYNC + DB - 1);
    bus_write(3'd3, 32'h001);
    check("race_irqA", 32'(irqA), 32'd1);
    check("race_irqB", 32'(irqB), 32'd0);
    idle(1);
    check("race_irq_hold", 32'(irqA), 32'd1);
    bus_read(3'd3, va, vb); check("race_EDGE", va, 32'h001);
    bus_write(3'd3, 32'h3FF);

    // Rising-only capture on B
    sw = 10'h008; idle(8);
    bus_read(3'd3, va, vb); check("rise_EDGE_B", vb, 32'h008); check("rise_EDGE_A", va, 32'h008);
    bus_write(3'd3, 32'h008);
    sw = 10'h000; idle(8);
    bus_read(3'd3, va, vb); check("fall_EDGE_B", vb, 32'h000); check("fall_EDGE_A", va, 32'h008);
    bus_write(3'd3, 32'h3FF);

    // Register access table
    foreach (vecs[k]) begin
      if (vecs[k].is_wr) begin
        bus_write(vecs[k].a, vecs[k].d);
        check($sformatf("vec%0d_ledr", k), 32'(ledA), vecs[k].exp);
      end else begin
        bus_read(vecs[k].a, va, vb);
        check($sformatf("vec%0d_rd", k), va, vecs[k].exp);
      end
    end

    // Reset mid-debounce discards the count
    sw = 10'h020; idle(SYNC + 2);
    rst = 1; idle(1); rst = 0;
    for (int i = 1; i <= 8; i++) begin
      bus_read(3'd0, va, vb);
      check($sformatf("rst_mid_DATA_%0d", i), 32'(va[5]), 32'(i >= SYNC + DB + 1));
    end

    // Randomised traffic against the model
    for (int n = 0; n < 800; n++) begin
      int op;
      if ($urandom_range(0, 7) == 0) sw[$urandom_range(0, 9)] ^= 1'b1;
      if ($urandom_range(0, 399) == 0) rst = 1;
      op = $urandom_range(0, 9);
      if (op <= 3)      cycle(0, 0, 3'd0, 32'd0);
      else if (op == 4) cycle(1, 0, 3'($urandom_range(0, 7)), 32'd0);
      else              cycle(0, 1, 3'($urandom_range(0, 7)), $urandom);
      rst = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sw_led_pio.md
# sw_led_pio

Parametrised Avalon-MM switch/LED peripheral that replaces the plain switch-in and LED-out PIOs in the Nios II demo system. Switch inputs are synchronised and debounced per bit. Edges are captured into a sticky register that can raise a maskable interrupt. LEDs get atomic set/clear registers, so firmware needs no read-modify-write. The block sits on the Nios data master, clocked by the system clock; its conduits export to the board switches and LEDR pins.

## Interface
- SW_WIDTH, 10, number of switch inputs (1..32)
- LED_WIDTH, 10, number of LED outputs (1..32)
- SYNC_STAGES, 2, synchroniser flops per switch bit (>=2)
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a new switch level (>=2); counter width is clog2(DEBOUNCE_CYCLES+1)
- EDGE_TYPE, 2, edge to capture: 0 rising, 1 falling, 2 both
- LED_RESET, 0, LED value loaded at reset

Ports:
- clk_clk  in  1  system clock; the only clock
- reset_reset  in  1  synchronous, active-high reset
- avs_address  in  3  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, valid 1 cycle after avs_read
- irq  out  1  interrupt, level, active-high
- switches_export  in  SW_WIDTH  raw asynchronous switch pins
- ledr_export  out  LED_WIDTH  LED drive, registered

## Operation
- Register map (word addresses):
  - 0 DATA (RO): debounced switch levels.
  - 1 LED (RW): the LED register.
  - 2 MASK (RW): irq mask, SW_WIDTH bits.
  - 3 EDGE (R, W1C): captured edges.
  - 4 LED_SET (WO): LED |= wdata.
  - 5 LED_CLR (WO): LED &= ~wdata.
  - 6 ID (RO): {8'hA5, 8'(LED_WIDTH), 8'(SW_WIDTH), 8'(EDGE_TYPE)}.
  - 7 reserved: reads 0, writes ignored.
- Unused upper bits read 0. Writes to RO registers are ignored. Reads to WO registers return 0.
- Each switch bit passes through SYNC_STAGES flops to give sync[i], then enters an independent debouncer:
  - If sync[i] == stable[i], cnt[i] is cleared.
  - Otherwise cnt[i] increments.
  - When cnt[i] == DEBOUNCE_CYCLES-1 and sync[i] still differs, stable[i] <= sync[i] and cnt[i] <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
- Edge detection: edge_evt[i] = stable[i] changed this cycle, qualified by EDGE_TYPE. edge_evt[i] sets EDGE[i].
- Writing 1 to EDGE[i] clears it. If edge_evt[i] and a W1C of bit i occur in the same cycle, the set wins and the bit stays 1.
- irq = |(EDGE & MASK), taken combinationally from registers, so it is glitch-free.
- Simultaneous LED_SET and LED_CLR is impossible on a single Avalon port. LED writes take effect on ledr_export the cycle after the write.
- Reset:
  - LED = LED_RESET; MASK = 0; EDGE = 0; stable = 0; cnt = 0; sync flops = 0; avs_readdata = 0; irq = 0.
  - A switch already high at reset is accepted after the normal debounce. With EDGE_TYPE 0 or 2 it then sets EDGE; firmware clears EDGE after boot.
  - Reset asserted mid-debounce discards the count.

## Timing
- Read latency is fixed at 1 cycle (readdatavalid not used). No waitrequest; writes complete in the strobe cycle.
- Pin-to-DATA latency: a pin level held steady appears in DATA after SYNC_STAGES + DEBOUNCE_CYCLES clock edges.
- The EDGE bit and irq assert on the same edge on which stable changes.
- A read of DATA or EDGE returns register state as of the read cycle. An edge landing in the read cycle is visible on the next read.
- W1C takes effect on the next edge. irq deasserts the cycle after the clearing write, unless the set-wins case applies.
- The counter saturates at no point, because it clears on acceptance. Wrap-around cannot occur.

## Test plan
- Reset check, with LED_RESET=10'h155: assert reset_reset 3 cycles -> ledr_export=10'h155, irq=0, read DATA=0, MASK=0, EDGE=0, ID=32'hA50A0A02.
- Debounce accept/reject, with DEBOUNCE_CYCLES=4, SYNC_STAGES=2:
  - Hold switch 0 high for 3 cycles, then low -> DATA stays 0, EDGE=0.
  - Hold it high for 8 cycles -> DATA bit0=1 exactly 6 cycles after the pin change; EDGE bit0=1.
- Interrupt and W1C race:
  - MASK=10'h001, rising edge on switch 0 -> irq=1.
  - Write EDGE=1 -> irq=0 next cycle.
  - Repeat with the W1C in the same cycle as edge_evt -> EDGE bit0 stays 1, irq stays 1.
- EDGE_TYPE=0 (rising only): switch 3 high then low, each held stable -> EDGE=10'h008 after the rise; no further set on the fall.
- LED atomics:
  - Write LED=10'h0F0, LED_SET=10'h003, LED_CLR=10'h010 -> ledr_export=10'h0E3.
  - Read LED returns 10'h0E3; read LED_SET returns 0.
- Reset mid-debounce: switch 5 high, assert reset after 2 of 4 debounce cycles, keep switch high -> DATA bit5=1 only after a full SYNC_STAGES+4 cycles after reset release.
